// File: rtl/first_system_sync.sv
// ---------------------------------------------------------------------------
// first_system_sync: resynchronised half-adder (carry/sum) with change pulse.
// Optional coverage ports behind FIRST_SYSTEM_COVER_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module first_system_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int CHG_PULSE   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in1,
  input  logic       in2,
  output logic       out1,
  output logic       out2,
  output logic       out_chg
`ifdef FIRST_SYSTEM_COVER_EN
  ,
  output logic [3:0] cov_mask,
  output logic [0:0] cov_done
`endif
);

  if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("first_system_sync: SYNC_STAGES must be in 1..4");
  end

  logic [SYNC_STAGES-1:0] r_sync1;
  logic [SYNC_STAGES-1:0] r_sync2;
  logic                   r_out1;
  logic                   r_out2;
  logic                   w_s1;
  logic                   w_s2;
  logic                   w_carry;
  logic                   w_sum;

  assign w_s1    = r_sync1[SYNC_STAGES-1];
  assign w_s2    = r_sync2[SYNC_STAGES-1];
  assign w_carry = w_s1 & w_s2;
  assign w_sum   = w_s1 ^ w_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_out1  <= 1'b0;
      r_out2  <= 1'b0;
    end else begin
      r_sync1[0] <= in1;
      r_sync2[0] <= in2;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync1[i] <= r_sync1[i-1];
        r_sync2[i] <= r_sync2[i-1];
      end
      r_out1 <= w_carry;
      r_out2 <= w_sum;
    end
  end

  assign out1 = r_out1;
  assign out2 = r_out2;

  // Compare the value about to be loaded with the one currently held, so the
  // pulse lines up with the cycle in which the new outputs first appear.
  if (CHG_PULSE != 0) begin : g_chg
    logic r_chg;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_chg <= 1'b0;
      end else begin
        r_chg <= ({w_carry, w_sum} != {r_out1, r_out2});
      end
    end
    assign out_chg = r_chg;
  end else begin : g_no_chg
    assign out_chg = 1'b0;
  end

`ifdef FIRST_SYSTEM_COVER_EN
  logic [3:0] r_cov_mask;
  logic       r_cov_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cov_mask <= 4'b0000;
      r_cov_done <= 1'b0;
    end else begin
      r_cov_mask <= r_cov_mask | (4'b0001 << {w_s1, w_s2});
      r_cov_done <= &r_cov_mask;
    end
  end

  assign cov_mask = r_cov_mask;
  assign cov_done = r_cov_done;
`endif

endmodule

`default_nettype wire

// File: tb/tb_first_system_sync.sv
// Bench for first_system_sync: reference model feeds a scoreboard queue that
// a free-running monitor drains one entry per clock edge.
`default_nettype none

module tb_first_system_sync;

  typedef struct {
    logic [1:0] o2st;
    logic       chg2st;
    logic [1:0] o1st;
    logic [3:0] cov;
    logic       cdone;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in1 = 1'b0;
  logic in2 = 1'b0;
  logic a_out1, a_out2, a_chg;
  logic b_out1, b_out2, b_chg;
  int   errors = 0;
  int   checks = 0;
  bit   done = 1'b0;

  exp_t       sbq[$];
  logic [1:0] hin[$];
  logic       hrst[$];

`ifdef FIRST_SYSTEM_COVER_EN
  logic [3:0] a_cov_mask, b_cov_mask;
  logic [0:0] a_cov_done, b_cov_done;
`endif

  always #5 clk = ~clk;

  first_system_sync #(.SYNC_STAGES(2), .CHG_PULSE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2),
    .out1(a_out1), .out2(a_out2), .out_chg(a_chg)
`ifdef FIRST_SYSTEM_COVER_EN
    , .cov_mask(a_cov_mask), .cov_done(a_cov_done)
`endif
  );

  first_system_sync #(.SYNC_STAGES(1), .CHG_PULSE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2),
    .out1(b_out1), .out2(b_out2), .out_chg(b_chg)
`ifdef FIRST_SYSTEM_COVER_EN
    , .cov_mask(b_cov_mask), .cov_done(b_cov_done)
`endif
  );

  // Value a synchroniser of depth s presents at the current edge: the input
  // sampled s edges ago, or 00 if any reset edge fell inside that window.
  function automatic logic [1:0] sync_val(int s);
    if (hin.size() <= s) return 2'b00;
    for (int k = 1; k <= s; k++) begin
      if (hrst[k] == 1'b0) return 2'b00;
    end
    return hin[s];
  endfunction

  // Half adder as plain arithmetic: {carry,sum} = a + b.
  function automatic logic [1:0] half_add(logic [1:0] v);
    return 2'(int'(v[1]) + int'(v[0]));
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model
  initial begin
    exp_t       e;
    logic [1:0] prev_o = 2'b00;
    logic [3:0] mask = 4'b0000;
    forever begin
      @(posedge clk);
      hin.push_front({in1, in2});
      hrst.push_front(rst_n);
      if (hin.size() > 8) begin
        void'(hin.pop_back());
        void'(hrst.pop_back());
      end
      e.o2st   = hrst[0] ? half_add(sync_val(2)) : 2'b00;
      e.o1st   = hrst[0] ? half_add(sync_val(1)) : 2'b00;
      e.chg2st = hrst[0] && (e.o2st != prev_o);
      prev_o   = e.o2st;
      if (!hrst[0]) begin
        mask    = 4'b0000;
        e.cdone = 1'b0;
      end else begin
        e.cdone = &mask;
        mask    = mask | (4'b0001 << sync_val(2));
      end
      e.cov = mask;
      sbq.push_back(e);
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (sbq.size() == 0) begin
        check("scoreboard_empty", 4'd1, 4'd0);
      end else begin
        e = sbq.pop_front();
        check("out_s2", {2'b00, a_out1, a_out2}, {2'b00, e.o2st});
        check("chg_s2", {3'b000, a_chg}, {3'b000, e.chg2st});
        check("out_s1", {2'b00, b_out1, b_out2}, {2'b00, e.o1st});
        check("chg_s1_tied", {3'b000, b_chg}, 4'd0);
`ifdef FIRST_SYSTEM_COVER_EN
        check("cov_mask", a_cov_mask, e.cov);
        check("cov_done", {3'b000, a_cov_done}, {3'b000, e.cdone});
`endif
      end
    end
  end

  task automatic set_in(input logic [1:0] v, input int cycles);
    {in1, in2} = v;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int waited;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    set_in(2'b00, 10);
    set_in(2'b01, 10);
    set_in(2'b10, 10);
    set_in(2'b11, 10);

    waited = 0;
    while (!a_out1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!a_out1) check("wait_out1_timeout", 4'd0, 4'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    set_in(2'b00, 5);
    in1 = 1'b1;
    #2;
    in1 = 1'b0;
    repeat (5) @(negedge clk);

    set_in(2'b11, 6);
    set_in(2'b00, 5);

    set_in(2'b00, 5);
    set_in(2'b01, 5);
    set_in(2'b10, 5);
    set_in(2'b11, 5);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #($urandom_range(0, 3));
      in1   = 1'($urandom_range(0, 1));
      in2   = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 39) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    done = 1'b1;
    #20;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/first_system_sync.md
Name: first_system_sync

Overview:
- Clocked two-input/two-output logic cell: out1 = in1 AND in2, out2 = in1 XOR in2 (half-adder carry/sum).
- Inputs are asynchronous to clk, so each is resynchronised before evaluation, and the outputs are registered.
- Serves as the minimal bring-up block of the first system: it exercises board inputs and drives two status outputs.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchroniser stages per input. Legal range 1..4; any value outside this range is an elaboration error.
- CHG_PULSE, 1, when 1, out_chg pulses on output changes; when 0, out_chg is tied to 0.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising clk edge.
- in1  input  1  operand A; asynchronous, level-sensitive.
- in2  input  1  operand B; asynchronous, level-sensitive.
- out1  output  1  registered in1 AND in2 (carry).
- out2  output  1  registered in1 XOR in2 (sum).
- out_chg  output  1  single-cycle pulse when {out1,out2} changed value on the previous edge.

Behaviour:
- Synchroniser:
  - in1 and in2 each pass through an independent SYNC_STAGES-deep shift register.
  - Synchroniser outputs are s1 and s2.
  - No glitch filtering; each input is a single bit, so no gray coding is needed.
- Output register:
  - On each rising edge with rst_n=1: out1 <= s1 & s2; out2 <= s1 ^ s2.
  - Latency from a stable input change to the output is exactly SYNC_STAGES+1 rising edges (3 at default).
- Change detect:
  - out_chg is registered.
  - On each edge with rst_n=1: out_chg <= ({s1&s2, s1^s2} != {out1,out2}).
  - out_chg is therefore high in the same cycle the new output values first appear, and for exactly one cycle per change.
  - If CHG_PULSE=0, out_chg is constant 0.
- Reset (rst_n=0 at a rising edge):
  - Clears all synchroniser flops, out1, out2 and out_chg to 0.
  - Takes effect at that edge and holds while rst_n stays low.
  - Reset mid-operation discards in-flight input samples.
- Reset release:
  - After the first edge with rst_n=1, the synchronisers resume sampling.
  - Outputs reflect the inputs after the normal latency, counted from the first non-reset edge.
  - out_chg can pulse at the first valid output update if the new value is not 00.
- Simultaneous changes of in1 and in2 within one cycle are evaluated together, with no intermediate output state.
- Output encoding, {in1,in2} -> {out1,out2}:
  - 00 -> 00
  - 01 -> 01
  - 10 -> 01
  - 11 -> 10
- No X propagation requirement beyond reset; every flop has a defined reset value.

Optional Feature:
- Macro FIRST_SYSTEM_COVER_EN.
- When defined, two extra output ports are added:
  - cov_mask [3:0]: bit k sets when the synchronised pair {s1,s2}==k is evaluated at an output-register update. Bits are sticky and cleared only by reset.
  - cov_done [0:0]: registered AND of all cov_mask bits.
- Both ports reset to 0.
- When the macro is undefined, these ports and their logic are absent and the port list is exactly as listed under Ports.

Test Plan:
1. Reset, then {in1,in2}=00 for 10 cycles -> out1=0, out2=0, out_chg=0 throughout.
2. From 00, step {in1,in2} through 01, 10, 11, changing the inputs every 10 cycles. Check at each step:
   - {out1,out2} = 01, then 01, then 10, each appearing exactly 3 edges after the input change.
   - out_chg pulses once at the 00->01 step and once at the 10->11 step.
   - out_chg does not pulse at the 01->10 step.
3. Hold 11 until out1=1, then assert rst_n=0 for one edge -> out1, out2 and out_chg are 0 at that edge. After release, out1=1 again exactly 3 edges later with a single out_chg pulse.
4. Toggle in1 00->10->00 within one cycle, between edges -> no output change and no out_chg pulse.
5. Set SYNC_STAGES=1 and apply 00->11 -> out1=1 exactly 2 edges after the change.
6. With FIRST_SYSTEM_COVER_EN defined, sweep 00, 01, 10, 11 (each held 5 cycles) -> cov_mask=1111 and cov_done=1. A subsequent reset returns both to 0.
